// File: rtl/spi_poll_master.sv
// Fixed-length full-duplex SPI frame master, triggered by an internal poll timer or a start pulse.
// Build option SPI_LOOPBACK_EN: receive path samples the registered mosi instead of the miso pin.
module spi_poll_master #(
  parameter int NBYTES      = 5,
  parameter int CLK_DIV     = 25,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int CS_SETUP    = 750,
  parameter int CS_HOLD     = 50,
  parameter int GAP_CYCLES  = 750,
  parameter int POLL_CYCLES = 500000
) (
  input  logic                clk50M,
  input  logic                rst,
  input  logic                enable,
  input  logic                start,
  input  logic [8*NBYTES-1:0] tx_data,
  output logic [8*NBYTES-1:0] rx_data,
  output logic                rx_valid,
  output logic                busy,
  output logic                cs,
  output logic                sck,
  output logic                mosi,
  input  logic                miso
);
  localparam int W        = 8*NBYTES;
  localparam int M1       = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int M2       = (GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV;
  localparam int CNT_MAX  = (M1 > M2) ? M1 : M2;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int PW       = $clog2(POLL_CYCLES);
  localparam int BW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD} state_t;

  state_t          state, nxt;
  logic [PW-1:0]   ptmr;
  logic            tick, req;
  logic [CW-1:0]   cnt;
  logic [3:0]      edge_cnt;
  logic [BW-1:0]   byte_cnt;
  logic [W-1:0]    tx_sr, rx_sr;
  logic            sin;
  logic            sck_evt, byte_end, last_byte;
  logic            setup_done, gap_done, hold_done;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign sin = mosi;
`else
  // two-flop synchroniser; CLK_DIV>=3 leaves room for its latency before each sample edge
  logic [1:0] miso_sync;
  always_ff @(posedge clk50M) begin
    if (rst) miso_sync <= '0;
    else     miso_sync <= {miso_sync[0], miso};
  end
  assign sin = miso_sync[1];
`endif

  // poll timer: wraps at POLL_CYCLES-1, held at zero while disabled
  assign tick = enable && (ptmr == PW'(POLL_CYCLES - 1));
  assign req  = tick || start;

  always_ff @(posedge clk50M) begin
    if (rst || !enable) ptmr <= '0;
    else if (tick)      ptmr <= '0;
    else                ptmr <= ptmr + 1'b1;
  end

  assign sck_evt    = (state == SHIFT) && (cnt == CW'(CLK_DIV - 1));
  assign byte_end   = sck_evt && (edge_cnt == 4'd15);
  assign last_byte  = (byte_cnt == BW'(NBYTES - 1));
  assign setup_done = (cnt == CW'(CS_SETUP - 1));
  assign gap_done   = (cnt == CW'(GAP_LAST));
  assign hold_done  = (cnt == CW'(CS_HOLD - 1));

  always_ff @(posedge clk50M) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (req) nxt = SETUP;
      SETUP:   if (setup_done) nxt = SHIFT;
      SHIFT:   if (byte_end) nxt = last_byte ? HOLD : ((GAP_CYCLES > 0) ? GAP : SHIFT);
      GAP:     if (gap_done) nxt = SHIFT;
      HOLD:    if (hold_done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      cs       <= 1'b1;
      sck      <= CPOL;
      mosi     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cnt      <= '0;
      edge_cnt <= '0;
      byte_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE || nxt != state || sck_evt) cnt <= '0;
      else                                          cnt <= cnt + 1'b1;

      unique case (state)
        IDLE: begin
          edge_cnt <= '0;
          byte_cnt <= '0;
          if (req) begin
            tx_sr <= tx_data;
            mosi  <= tx_data[W-1];
            cs    <= 1'b0;
          end
        end
        SHIFT: if (sck_evt) begin
          sck      <= ~sck;
          edge_cnt <= edge_cnt + 1'b1;
          if (byte_end) byte_cnt <= byte_cnt + 1'b1;
          if (!edge_cnt[0]) begin
            if (!CPHA) rx_sr <= {rx_sr[W-2:0], sin};
            else       mosi  <= tx_sr[W-1];
          end else if (!CPHA) begin
            tx_sr <= tx_sr << 1;
            if (!(byte_end && last_byte)) mosi <= tx_sr[W-2];
          end else begin
            rx_sr <= {rx_sr[W-2:0], sin};
            tx_sr <= tx_sr << 1;
            // park the next byte's MSB on mosi for the whole gap
            if (byte_end && !last_byte && GAP_CYCLES > 0) mosi <= tx_sr[W-2];
          end
        end
        HOLD: if (hold_done) begin
          cs       <= 1'b1;
          rx_data  <= rx_sr;
          rx_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_poll_master.sv
// Directed bench: mode-0 and mode-3 masters side by side, each with a clocked SPI slave model.
module tb_spi_poll_master;
  localparam int W = 40;
  localparam logic [W-1:0] SLV = 40'hA55A1234C3;
`ifdef SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif
  // 6 + 5*16*4 + 4*5 + 3
  localparam int FRAME_LEN = 349;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst, enable, start;
  logic [W-1:0] tx_data;
  logic [W-1:0] rx_data_w [2];
  logic rx_valid_w [2], busy_w [2], cs_w [2], sck_w [2], mosi_w [2], miso_w [2];

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_poll_master #(.NBYTES(5), .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0), .CS_SETUP(6),
    .CS_HOLD(3), .GAP_CYCLES(5), .POLL_CYCLES(2000)) dut0 (
    .clk50M(clk), .rst(rst), .enable(enable), .start(start), .tx_data(tx_data),
    .rx_data(rx_data_w[0]), .rx_valid(rx_valid_w[0]), .busy(busy_w[0]), .cs(cs_w[0]),
    .sck(sck_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0]));

  spi_poll_master #(.NBYTES(5), .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b1), .CS_SETUP(6),
    .CS_HOLD(3), .GAP_CYCLES(5), .POLL_CYCLES(2000)) dut1 (
    .clk50M(clk), .rst(rst), .enable(enable), .start(start), .tx_data(tx_data),
    .rx_data(rx_data_w[1]), .rx_valid(rx_valid_w[1]), .busy(busy_w[1]), .cs(cs_w[1]),
    .sck(sck_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1]));

  // slave + monitor per master; sampled at clk posedge so every value is the pre-edge one
  for (genvar g = 0; g < 2; g++) begin : mon
    int vcnt = 0, falls = 0, fall_t = 0, prev_fall_t = 0, low_run = 0, dur = 0, edges = 0;
    logic prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0, miso_q = 1'b0;
    logic [W-1:0] sh = '0, cap = '0;
    assign miso_w[g] = miso_q;
    always @(posedge clk) begin
      prev_cs   <= cs_w[g];
      prev_sck  <= sck_w[g];
      prev_mosi <= mosi_w[g];
      if (rx_valid_w[g]) vcnt <= vcnt + 1;
      if (prev_cs && !cs_w[g]) begin
        falls <= falls + 1; prev_fall_t <= fall_t; fall_t <= cyc;
        low_run <= 1; edges <= 0; cap <= '0;
        if (g == 0) begin miso_q <= SLV[W-1]; sh <= SLV << 1; end
        else sh <= SLV;
      end else if (!cs_w[g]) begin
        low_run <= low_run + 1;
        if (sck_w[g] != prev_sck) begin
          edges <= edges + 1;
          if (sck_w[g]) cap <= {cap[W-2:0], prev_mosi};
          else begin miso_q <= sh[W-1]; sh <= sh << 1; end
        end
      end
      if (!prev_cs && cs_w[g]) dur <= low_run;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [W-1:0] exp_rx(input logic [W-1:0] tx);
    return LOOPBACK ? tx : SLV;
  endfunction

  task automatic wait_done(input int lim);
    int n, c0;
    n = 0; c0 = mon[0].vcnt;
    while (mon[0].vcnt == c0 && n < lim) begin @(negedge clk); n++; end
    check("frame_done_timeout", 64'(n < lim), 64'd1);
  endtask

  task automatic chk_rst_state(input string s);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_cs%0d", s, g),    64'(cs_w[g]),       64'd1);
      check($sformatf("%s_sck%0d", s, g),   64'(sck_w[g]),      64'(g == 1));
      check($sformatf("%s_mosi%0d", s, g),  64'(mosi_w[g]),     64'd0);
      check($sformatf("%s_busy%0d", s, g),  64'(busy_w[g]),     64'd0);
      check($sformatf("%s_rxv%0d", s, g),   64'(rx_valid_w[g]), 64'd0);
      check($sformatf("%s_rxd%0d", s, g),   64'(rx_data_w[g]),  64'd0);
    end
  endtask

  task automatic run_frame(input logic [W-1:0] tx, input string s, input bit disrupt);
    int v0, v1;
    v0 = mon[0].vcnt; v1 = mon[1].vcnt;
    tx_data = tx; start = 1'b1; step(1); start = 1'b0;
    check({s, "_busy0"}, 64'(busy_w[0]), 64'd1);
    check({s, "_busy1"}, 64'(busy_w[1]), 64'd1);
    if (disrupt) begin
      step(100);
      tx_data = ~tx; start = 1'b1; step(1); start = 1'b0;
    end
    wait_done(1000);
    if (disrupt) step(400);
    check({s, "_rx0"},    64'(rx_data_w[0]),     64'(exp_rx(tx)));
    check({s, "_rx1"},    64'(rx_data_w[1]),     64'(exp_rx(tx)));
    check({s, "_mosi0"},  64'(mon[0].cap),       64'(tx));
    check({s, "_mosi1"},  64'(mon[1].cap),       64'(tx));
    check({s, "_csdur0"}, 64'(mon[0].dur),       64'(FRAME_LEN));
    check({s, "_csdur1"}, 64'(mon[1].dur),       64'(FRAME_LEN));
    check({s, "_edges0"}, 64'(mon[0].edges),     64'd80);
    check({s, "_edges1"}, 64'(mon[1].edges),     64'd80);
    check({s, "_nvld0"},  64'(mon[0].vcnt - v0), 64'd1);
    check({s, "_nvld1"},  64'(mon[1].vcnt - v1), 64'd1);
    check({s, "_idle0"},  64'(busy_w[0]),        64'd0);
    check({s, "_idle1"},  64'(busy_w[1]),        64'd0);
    check({s, "_sck0"},   64'(sck_w[0]),         64'd0);
    check({s, "_sck1"},   64'(sck_w[1]),         64'd1);
  endtask

  initial begin
    int f0, f1, v0;
    rst = 1'b1; enable = 1'b0; start = 1'b0; tx_data = '0;
    step(3);
    chk_rst_state("reset");
    rst = 1'b0;
    step(2);

    run_frame(40'h8300000000, "f1", 1'b0);
    // mid-frame start and tx_data change must not disturb the frame or queue a second one
    run_frame(40'h8300000000, "f2", 1'b1);

    // reset around bit 17 of a frame
    tx_data = 40'h8300000000; start = 1'b1; step(1); start = 1'b0;
    step(155);
    rst = 1'b1; step(1);
    chk_rst_state("midrst");
    rst = 1'b0;
    v0 = mon[0].vcnt;
    step(600);
    check("midrst_novalid", 64'(mon[0].vcnt - v0), 64'd0);
    check("midrst_rxkeep",  64'(rx_data_w[0]),     64'd0);
    run_frame(40'h0123456789, "f3", 1'b0);

    // poll timer: 10000 enabled cycles -> 5 ticks, 2000 apart
    f0 = mon[0].falls; f1 = mon[1].falls;
    enable = 1'b1; step(10000); enable = 1'b0;
    step(400);
    check("poll_frames0", 64'(mon[0].falls - f0), 64'd5);
    check("poll_frames1", 64'(mon[1].falls - f1), 64'd5);
    check("poll_period0", 64'(mon[0].fall_t - mon[0].prev_fall_t), 64'd2000);
    check("poll_rx0",     64'(rx_data_w[0]), 64'(exp_rx(40'h0123456789)));
    step(3000);
    check("poll_off0", 64'(mon[0].falls - f0), 64'd5);

    // tick at 2000 lands inside a start-triggered frame and is dropped
    f0 = mon[0].falls; v0 = mon[0].vcnt;
    enable = 1'b1; step(1800);
    start = 1'b1; step(1); start = 1'b0;
    step(700); enable = 1'b0;
    step(400);
    check("tickdrop_frames", 64'(mon[0].falls - f0), 64'd1);
    check("tickdrop_valid",  64'(mon[0].vcnt - v0),  64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_poll_master.md
Name: spi_poll_master

Overview:
- Parametrised SPI master that runs fixed-length full-duplex frames, either periodically from an internal poll timer or on demand.
- Successor to the fixed 40-bit joystick poll: byte count, SCK rate, SPI mode, CS timing, inter-byte gap and poll period are all parameters.
- Sits between board-level SPI pins and consumer logic, such as joystick decode or the hex display.
- Delivers each received frame as a wide word with a one-cycle valid strobe.

Parameters:
NBYTES, 5, bytes per frame (1..16); data width W = 8*NBYTES
CLK_DIV, 25, clk50M cycles per SCK half-period (>=1); SCK = 50MHz/(2*CLK_DIV)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
CS_SETUP, 750, cycles from cs low to first SCK edge (>=1)
CS_HOLD, 50, cycles from last SCK edge to cs high (>=1)
GAP_CYCLES, 750, idle cycles between bytes with cs held low (0 = none)
POLL_CYCLES, 500000, poll period in clk50M cycles (>=2)

Ports:
clk50M  in  1  system clock, 50 MHz
rst  in  1  synchronous active-high reset
enable  in  1  poll timer runs while 1; timer clears to 0 while 0
start  in  1  single-cycle request for one frame
tx_data  in  W  frame to send; byte [W-1:W-8] goes first
rx_data  out  W  last completed received frame; first byte lands in [W-1:W-8]
rx_valid  out  1  one-cycle pulse when rx_data updates
busy  out  1  high while the FSM is not IDLE
cs  out  1  chip select, active low
sck  out  1  SPI clock
mosi  out  1  master out
miso  in  1  master in

Behaviour:
- Reset values (rst high at a clk50M edge, including mid-frame): cs=1, sck=CPOL, mosi=0, rx_data=0, rx_valid=0, busy=0, FSM=IDLE, all counters 0. A partial frame is discarded and rx_data is not updated.
- Poll timer:
  - Counts 0..POLL_CYCLES-1 while enable=1, then wraps.
  - A tick is generated at the wrap.
  - A frame request is tick OR start.
  - A request is accepted only in IDLE. Requests while busy are dropped, not queued.
- FSM states: IDLE, SETUP, SHIFT, GAP, HOLD.
- IDLE:
  - On an accepted request: latch tx_data into the shift register, cs<=0, busy<=1, go to SETUP.
  - mosi is driven with the first bit on entry to SETUP.
- SETUP: wait CS_SETUP cycles, then SHIFT.
- SHIFT:
  - SCK toggles every CLK_DIV cycles; 16 edges per byte.
  - CPHA=0: sample miso on odd (leading) edges; shift mosi on even (trailing) edges, except after the final bit.
  - CPHA=1: shift mosi on leading edges (the first leading edge presents the MSB); sample on trailing edges.
  - Bits are MSB first.
  - After the 16th edge: if bytes remain and GAP_CYCLES>0, go to GAP; if bytes remain and GAP_CYCLES=0, continue SHIFT; otherwise go to HOLD.
- GAP:
  - sck=CPOL and cs=0 for GAP_CYCLES cycles, then SHIFT.
  - mosi holds the next byte's MSB throughout GAP.
- HOLD:
  - Wait CS_HOLD cycles, then on the same edge: cs<=1, rx_data<=received frame, rx_valid<=1 for one cycle, busy<=0, go to IDLE.
- Frame duration: cs low for exactly CS_SETUP + NBYTES*16*CLK_DIV + (NBYTES-1)*GAP_CYCLES + CS_HOLD cycles.
- sck is registered with no glitches; sck returns to CPOL before HOLD.
- A request in the same cycle as the HOLD->IDLE transition is dropped. The next request accepted is the first one seen in IDLE.
- start and tick in the same cycle count as one request.
- tx_data changes after acceptance do not affect the frame in flight.

Optional Feature:
SPI_LOOPBACK_EN
- Defined: an internal loopback replaces the miso pin input with the registered mosi, so rx_data equals the frame sent. The miso port is ignored.
- Undefined: miso is sampled directly, with a 2-flop synchroniser before the sample point. Synchroniser latency is covered because CLK_DIV>=3 is required when the macro is undefined.

Test Plan:
- NBYTES=5, CLK_DIV=4, mode 0, start pulse, tx=0x8300000000, slave model returns 0xA55A1234C3 -> mosi bits match 0x83 then zeros MSB-first; rx_data=0xA55A1234C3; one rx_valid pulse; cs low for the computed cycle count.
- CPOL=1, CPHA=1, same data -> sck idles high; sampling on rising (trailing) edges yields 0xA55A1234C3; sck=1 in GAP and after HOLD.
- POLL_CYCLES=2000, enable=1 for 10000 cycles, frame <2000 cycles -> exactly 5 frames, cs falling edges 2000 cycles apart; enable=0 -> no further frames.
- start pulse while busy and tick during a frame -> both dropped; only one rx_valid per frame; tx_data change mid-frame does not alter mosi.
- rst asserted at bit 17 of a frame -> next edge cs=1, sck=CPOL, busy=0, rx_valid never pulses, rx_data stays at its prior value 0; new start gives a clean full frame.
- SPI_LOOPBACK_EN defined, tx=0x0123456789 -> rx_data=0x0123456789 regardless of miso held at 1.
